uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have ports: uart_clk  input  1  receive clock, rising edge.
REQ-002 SHALL have ports: sys_rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: uart_en  input  1  receiver enable (CON[0]).
REQ-004 SHALL have ports: uart_rxd  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have ports: uart_baud  input  16  bit period P = uart_baud+1 uart_clk cycles; legal range uart_baud >= 3.
REQ-006 SHALL have ports: uart_prty_en  input  1  9-bit frame enable (CON[3]).
REQ-007 SHALL have ports: uart_rxie  input  1  receive interrupt enable (CON[2]).
REQ-008 SHALL have ports: uart_rxpnd_clr  input  1  one-cycle pulse, clears pending/error flags (CON write, bit 11).
REQ-009 SHALL have ports: rx_data  output  8  last received data byte.
REQ-010 SHALL have ports: rx_bit9  output  1  received 9th bit (valid when uart_prty_en=1, else 0).
REQ-011 SHALL have ports: rx_pnd  output  1  byte-received pending flag.
REQ-012 SHALL have ports: rx_ferr  output  1  framing error flag (stop bit sampled 0).
REQ-013 SHALL have ports: rx_ovf  output  1  overrun flag.
REQ-014 SHALL have ports: rx_int  output  1  rx_pnd & uart_rxie, combinational.
REQ-015 Reset SHALL be sys_rstn, asynchronous, active-low; clock SHALL be uart_clk.

Function
REQ-016 uart_rxd SHALL pass through a 2-flop synchronizer (reset value 1), followed by a 1-flop edge-detect register (reset value 1); all decoding uses the synchronized signal rxs.
REQ-017 FSM states SHALL be IDLE, START, DATA, BIT9, STOP; reset/idle state SHALL be IDLE.
REQ-018 IDLE -> START when uart_en=1 and a falling edge on rxs is detected (cycle t); the 16-bit bit counter SHALL load 0.
REQ-019 START: rxs SHALL be sampled at cycle t + floor(P/2); if rxs=1 -> IDLE (false start, no flag change); else -> DATA with counter cleared.
REQ-020 DATA: SHALL sample every P cycles after the start-bit sample, 8 bits, LSB first, into a shift register; after bit 7 -> BIT9 if uart_prty_en=1, else -> STOP.
REQ-021 BIT9: SHALL sample one bit P cycles later into a bit9 holding register; the bit is stored raw with no parity check; -> STOP.
REQ-022 STOP: SHALL sample P cycles after the previous sample, then -> IDLE in the same cycle; the next falling edge is accepted from the following cycle.
REQ-023 On the stop-sample cycle, if rx_pnd=0 or uart_rxpnd_clr=1: rx_data and rx_bit9 SHALL update on the next edge, rx_pnd SHALL be set, and rx_ferr SHALL be set if the stop bit was 0.
REQ-024 On the stop-sample cycle, if rx_pnd=1 and uart_rxpnd_clr=0: rx_data and rx_bit9 SHALL NOT change, and rx_ovf SHALL be set.
REQ-025 Latency: rx_pnd SHALL rise 1 cycle after the stop-sample cycle, which is t + floor(P/2) + 9P (or + 10P with 9-bit frames).
REQ-026 uart_rxpnd_clr SHALL clear rx_pnd, rx_ferr and rx_ovf; when set and clear occur in the same cycle, set SHALL win.
REQ-027 Bit counter SHALL be 16-bit and SHALL reset to 0 at every sample point; it SHALL never wrap within legal uart_baud values.
REQ-028 uart_en=0 SHALL force the FSM to IDLE and the counter to 0 within one cycle, aborting any frame in progress; rx_data, rx_bit9 and the flags SHALL be retained.
REQ-029 uart_baud changes mid-frame SHALL take effect at the next sample interval; no recovery is required.
REQ-030 rx_bit9 SHALL be 0 when the frame was received with uart_prty_en=0.

Reset
REQ-031 Asynchronous assertion of sys_rstn SHALL drive: FSM=IDLE, counter=0, synchronizer/edge registers=1, rx_data=0x00, rx_bit9=0, rx_pnd=0, rx_ferr=0, rx_ovf=0, rx_int=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; after release, the line SHALL need a fresh high-to-low edge before reception restarts.

Verification
REQ-033 Scenario: uart_baud=15, prty_en=0, frame 0x55 with stop=1 -> rx_data=0x55, rx_pnd=1, rx_ferr=0, rx_ovf=0, rx_int=rxie.
REQ-034 Scenario: uart_baud=15, rxd low for 3 cycles then high -> FSM returns to IDLE; no flag or data change.
REQ-035 Scenario: frame 0xA3 with stop bit 0 -> rx_data=0xA3, rx_pnd=1, rx_ferr=1; then rxpnd_clr -> all flags 0.
REQ-036 Scenario: two frames 0x12 then 0x34 with no clear between -> rx_data=0x12, rx_ovf=1; clear pulsed on the stop-sample cycle of frame 2 -> rx_data=0x34, rx_pnd=1, rx_ovf=0.
REQ-037 Scenario: prty_en=1, data 0x0F, bit9=1 -> rx_data=0x0F, rx_bit9=1, and rx_pnd rises at t+floor(P/2)+10P+1.
REQ-038 Scenario: uart_en deasserted at DATA bit 4, then sys_rstn pulsed mid-frame on a second run -> no rx_pnd in either case, and outputs hold their reset values after the reset pulse.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive path: line synchroniser, start/data/9th/stop bit sampling FSM,
// and the pending / framing-error / overrun status flags.
module uart_receiver (
    input  logic        uart_clk,
    input  logic        sys_rstn,
    input  logic        uart_en,
    input  logic        uart_rxd,
    input  logic [15:0] uart_baud,
    input  logic        uart_prty_en,
    input  logic        uart_rxie,
    input  logic        uart_rxpnd_clr,
    output logic [7:0]  rx_data,
    output logic        rx_bit9,
    output logic        rx_pnd,
    output logic        rx_ferr,
    output logic        rx_ovf,
    output logic        rx_int
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StBit9, StStop} state_e;

    state_e      state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        bit9_hold;
    logic        rx_meta;
    logic        rxs;
    logic        rxs_prev;

    logic [16:0] half_period;
    logic        start_hit;
    logic        bit_hit;
    logic        fall_edge;
    logic        accept;

    // 17-bit arithmetic so uart_baud = 0xFFFF cannot overflow P.
    assign half_period = ({1'b0, uart_baud} + 17'd1) >> 1;
    // >= rather than == so a mid-frame baud decrease still reaches a sample point.
    assign start_hit   = ({1'b0, bit_cnt} + 17'd1) >= half_period;
    assign bit_hit     = bit_cnt >= uart_baud;
    assign fall_edge   = rxs_prev & ~rxs;
    assign accept      = ~rx_pnd | uart_rxpnd_clr;
    assign rx_int      = rx_pnd & uart_rxie;

    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= uart_rxd;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state     <= StIdle;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            bit9_hold <= 1'b0;
            rx_data   <= 8'h00;
            rx_bit9   <= 1'b0;
            rx_pnd    <= 1'b0;
            rx_ferr   <= 1'b0;
            rx_ovf    <= 1'b0;
        end else begin
            if (uart_rxpnd_clr) begin
                rx_pnd  <= 1'b0;
                rx_ferr <= 1'b0;
                rx_ovf  <= 1'b0;
            end
            if (!uart_en) begin
                state   <= StIdle;
                bit_cnt <= 16'd0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (fall_edge) begin
                            state   <= StStart;
                            bit_cnt <= 16'd0;
                        end
                    end
                    StStart: begin
                        if (start_hit) begin
                            bit_cnt   <= 16'd0;
                            bit_idx   <= 3'd0;
                            bit9_hold <= 1'b0;
                            state     <= rxs ? StIdle : StData;
                        end else begin
                            bit_cnt <= bit_cnt + 16'd1;
                        end
                    end
                    StData: begin
                        if (bit_hit) begin
                            bit_cnt   <= 16'd0;
                            shift_reg <= {rxs, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= uart_prty_en ? StBit9 : StStop;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 16'd1;
                        end
                    end
                    StBit9: begin
                        if (bit_hit) begin
                            bit_cnt   <= 16'd0;
                            bit9_hold <= rxs;
                            state     <= StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 16'd1;
                        end
                    end
                    StStop: begin
                        if (bit_hit) begin
                            bit_cnt <= 16'd0;
                            state   <= StIdle;
                            // Set beats a same-cycle clear; an unread byte is kept on overrun.
                            if (accept) begin
                                rx_data <= shift_reg;
                                rx_bit9 <= bit9_hold;
                                rx_pnd  <= 1'b1;
                                if (!rxs) begin
                                    rx_ferr <= 1'b1;
                                end
                            end else begin
                                rx_ovf <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state   <= StIdle;
                        bit_cnt <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a frame-level model predicts every output each cycle,
// plus hand-computed literal checks of data, flags and pending latency.
module tb_uart_receiver;

    logic        uart_clk;
    logic        sys_rstn;
    logic        uart_en;
    logic        uart_rxd;
    logic [15:0] uart_baud;
    logic        uart_prty_en;
    logic        uart_rxie;
    logic        uart_rxpnd_clr;
    logic [7:0]  rx_data;
    logic        rx_bit9;
    logic        rx_pnd;
    logic        rx_ferr;
    logic        rx_ovf;
    logic        rx_int;

    uart_receiver dut (
        .uart_clk       (uart_clk),
        .sys_rstn       (sys_rstn),
        .uart_en        (uart_en),
        .uart_rxd       (uart_rxd),
        .uart_baud      (uart_baud),
        .uart_prty_en   (uart_prty_en),
        .uart_rxie      (uart_rxie),
        .uart_rxpnd_clr (uart_rxpnd_clr),
        .rx_data        (rx_data),
        .rx_bit9        (rx_bit9),
        .rx_pnd         (rx_pnd),
        .rx_ferr        (rx_ferr),
        .rx_ovf         (rx_ovf),
        .rx_int         (rx_int)
    );

    typedef struct {
        int         stop_cyc;
        logic [7:0] data;
        logic       bit9;
        logic       stop;
    } frame_t;

    frame_t     exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         last_k0 = 0;
    int         pnd_rise_cyc = -1;
    logic       pnd_seen = 1'b0;

    logic [7:0] m_data = 8'h00;
    logic       m_bit9 = 1'b0;
    logic       m_pnd  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovf  = 1'b0;

    initial begin
        uart_clk = 1'b0;
        forever #5 uart_clk = ~uart_clk;
    end

    initial forever begin
        @(posedge uart_clk);
        cyc++;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: registers seen during cycle cyc; the next state is built from this cycle's inputs.
    initial forever begin
        frame_t f;
        logic [7:0] n_data;
        logic       n_bit9, n_pnd, n_ferr, n_ovf;
        @(negedge uart_clk);
        if (!sys_rstn) begin
            m_data = 8'h00; m_bit9 = 1'b0; m_pnd = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
            exp_q.delete();
        end
        check("rx_data", 16'(rx_data), 16'(m_data));
        check("rx_bit9", 16'(rx_bit9), 16'(m_bit9));
        check("rx_pnd",  16'(rx_pnd),  16'(m_pnd));
        check("rx_ferr", 16'(rx_ferr), 16'(m_ferr));
        check("rx_ovf",  16'(rx_ovf),  16'(m_ovf));
        check("rx_int",  16'(rx_int),  16'(m_pnd & uart_rxie));
        if (rx_pnd && !pnd_seen) pnd_rise_cyc = cyc;
        pnd_seen = rx_pnd;
        if (sys_rstn) begin
            n_data = m_data; n_bit9 = m_bit9; n_pnd = m_pnd; n_ferr = m_ferr; n_ovf = m_ovf;
            if (uart_rxpnd_clr) begin
                n_pnd = 1'b0; n_ferr = 1'b0; n_ovf = 1'b0;
            end
            if (exp_q.size() > 0 && exp_q[0].stop_cyc == cyc) begin
                f = exp_q.pop_front();
                if (!m_pnd || uart_rxpnd_clr) begin
                    n_data = f.data;
                    n_bit9 = f.bit9;
                    n_pnd  = 1'b1;
                    if (!f.stop) n_ferr = 1'b1;
                end else begin
                    n_ovf = 1'b1;
                end
            end
            m_data = n_data; m_bit9 = n_bit9; m_pnd = n_pnd; m_ferr = n_ferr; m_ovf = n_ovf;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic hold_bit(input logic v, input int p);
        uart_rxd = v;
        tick(p);
    endtask

    task automatic pulse_clr();
        uart_rxpnd_clr = 1'b1;
        tick(1);
        uart_rxpnd_clr = 1'b0;
        tick(1);
    endtask

    // Stop-sample cycle = k0 + 2 (synchroniser) + floor(P/2) + nb*P, k0 = start-bit drive cycle.
    task automatic send_frame(input logic [7:0] d, input logic b9, input logic stop_bit,
                              input logic nine, input logic clr_at_stop);
        int p, h, nb;
        frame_t f;
        p = int'(uart_baud) + 1;
        h = p / 2;
        nb = nine ? 10 : 9;
        uart_prty_en = nine;
        tick(1);
        last_k0    = cyc;
        f.stop_cyc = cyc + 2 + h + nb * p;
        f.data     = d;
        f.bit9     = nine ? b9 : 1'b0;
        f.stop     = stop_bit;
        exp_q.push_back(f);
        hold_bit(1'b0, p);
        for (int i = 0; i < 8; i++) hold_bit(d[i], p);
        if (nine) hold_bit(b9, p);
        uart_rxd = stop_bit;
        for (int j = 0; j < p; j++) begin
            uart_rxpnd_clr = clr_at_stop && (j == h + 2);
            tick(1);
        end
        uart_rxpnd_clr = 1'b0;
        uart_rxd = 1'b1;
        tick(4);
    endtask

    // Drives start and nbits data bits, then half of the next bit; caller aborts the frame.
    task automatic send_partial(input logic [7:0] d, input int nbits);
        int p;
        p = int'(uart_baud) + 1;
        tick(1);
        hold_bit(1'b0, p);
        for (int i = 0; i < nbits; i++) hold_bit(d[i], p);
        uart_rxd = d[nbits];
        tick(p / 2);
    endtask

    initial begin
        sys_rstn = 1'b0;
        uart_en = 1'b1;
        uart_rxd = 1'b1;
        uart_baud = 16'd15;
        uart_prty_en = 1'b0;
        uart_rxie = 1'b1;
        uart_rxpnd_clr = 1'b0;
        tick(3);
        check("reset rx_data", 16'(rx_data), 16'h00);
        check("reset rx_pnd", 16'(rx_pnd), 16'h0);
        check("reset rx_int", 16'(rx_int), 16'h0);
        sys_rstn = 1'b1;
        tick(5);

        // 0x55, 8-bit, good stop
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        check("s1 rx_data", 16'(rx_data), 16'h55);
        check("s1 rx_pnd", 16'(rx_pnd), 16'h1);
        check("s1 rx_ferr", 16'(rx_ferr), 16'h0);
        check("s1 rx_ovf", 16'(rx_ovf), 16'h0);
        check("s1 rx_int", 16'(rx_int), 16'h1);
        uart_rxie = 1'b0;
        tick(1);
        check("s1 rx_int masked", 16'(rx_int), 16'h0);
        uart_rxie = 1'b1;
        pulse_clr();

        // false start: 3 low cycles
        uart_rxd = 1'b0;
        tick(3);
        uart_rxd = 1'b1;
        tick(60);
        check("false start rx_pnd", 16'(rx_pnd), 16'h0);
        check("false start rx_data", 16'(rx_data), 16'h55);

        // framing error
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ferr rx_data", 16'(rx_data), 16'hA3);
        check("ferr rx_pnd", 16'(rx_pnd), 16'h1);
        check("ferr rx_ferr", 16'(rx_ferr), 16'h1);
        pulse_clr();
        check("clr flags", 16'({rx_pnd, rx_ferr, rx_ovf}), 16'h0);

        // overrun, then clear on the stop-sample cycle
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovf rx_data", 16'(rx_data), 16'h12);
        check("ovf rx_ovf", 16'(rx_ovf), 16'h1);
        check("ovf rx_pnd", 16'(rx_pnd), 16'h1);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b1);
        check("clr-at-stop rx_data", 16'(rx_data), 16'h34);
        check("clr-at-stop rx_pnd", 16'(rx_pnd), 16'h1);
        check("clr-at-stop rx_ovf", 16'(rx_ovf), 16'h0);
        pulse_clr();

        // 9-bit frame: pending rises at k0 + 2 + 8 + 10*16 + 1
        pnd_rise_cyc = -1;
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
        check("nine rx_data", 16'(rx_data), 16'h0F);
        check("nine rx_bit9", 16'(rx_bit9), 16'h1);
        check("nine latency", 16'(pnd_rise_cyc - last_k0), 16'd171);
        pulse_clr();
        pnd_rise_cyc = -1;
        send_frame(8'hC6, 1'b1, 1'b1, 1'b0, 1'b0);
        check("eight rx_bit9", 16'(rx_bit9), 16'h0);
        check("eight latency", 16'(pnd_rise_cyc - last_k0), 16'd155);
        pulse_clr();

        // odd and minimum bit periods
        uart_baud = 16'd10;
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        check("baud10 rx_data", 16'(rx_data), 16'h81);
        pulse_clr();
        uart_baud = 16'd3;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        check("baud3 rx_data", 16'(rx_data), 16'h3C);
        check("baud3 rx_pnd", 16'(rx_pnd), 16'h1);
        pulse_clr();
        uart_baud = 16'd15;

        // enable dropped during data bit 4, line returns idle
        send_partial(8'h00, 4);
        uart_en = 1'b0;
        uart_rxd = 1'b1;
        tick(20);
        uart_en = 1'b1;
        tick(80);
        check("en abort rx_pnd", 16'(rx_pnd), 16'h0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after abort rx_data", 16'(rx_data), 16'h5A);
        check("after abort rx_pnd", 16'(rx_pnd), 16'h1);
        pulse_clr();

        // reset pulse mid-frame
        send_partial(8'h00, 4);
        sys_rstn = 1'b0;
        uart_rxd = 1'b1;
        tick(3);
        sys_rstn = 1'b1;
        tick(120);
        check("rst abort rx_data", 16'(rx_data), 16'h00);
        check("rst abort flags", 16'({rx_bit9, rx_pnd, rx_ferr, rx_ovf, rx_int}), 16'h0);
        send_frame(8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after reset rx_data", 16'(rx_data), 16'h99);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
